// File: rtl/pixel_ram_pkg.sv
// pixel_ram_pkg: shared types for the dual-port pixel memory.
// Clear-engine state, read-during-write mode and latency bound.
package pixel_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_t;

  typedef enum logic {
    READ_FIRST,
    WRITE_FIRST
  } rdw_mode_t;

  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/pixel_ram_clr_fsm.sv
// pixel_ram_clr_fsm: sweeps every address writing one latched colour.
// Busy spans the sweep plus a two-cycle tail in DONE ending on the done pulse.
module pixel_ram_clr_fsm
  import pixel_ram_pkg::*;
#(
  parameter int Dword  = 16384,
  parameter int Dwidth = 12,
  parameter int Awidth = $clog2(Dword)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  input  logic [Dwidth-1:0] clr_value,
  output logic              clr_we,
  output logic [Awidth-1:0] clr_addr,
  output logic [Dwidth-1:0] clr_data,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam logic [Awidth-1:0] LAST = Awidth'(Dword - 1);

  clr_state_t        state_q, state_d;
  logic [Awidth-1:0] ptr_q, ptr_d;
  logic [Dwidth-1:0] val_q, val_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    val_d   = val_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          val_d   = clr_value;
          ptr_d   = '0;
          busy_d  = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST) begin
          state_d = DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      DONE: begin
        // first DONE cycle raises the pulse, second retires busy
        if (!done_q) begin
          done_d = 1'b1;
        end else begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      val_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = ptr_q;
  assign clr_data = val_q;
  assign clr_busy = busy_q;
  assign clr_done = done_q;

endmodule

// File: rtl/pixel_ram_dp.sv
// pixel_ram_dp: simple-dual-port pixel store with clear engine.
// Write port is shared between drawing logic and the clear sweep.
module pixel_ram_dp
  import pixel_ram_pkg::*;
#(
  parameter int        Dword     = 16384,
  parameter int        Dwidth    = 12,
  parameter int        Awidth    = $clog2(Dword),
  parameter string     initfile  = "Meminit.txt",
  parameter int        RD_LAT    = 1,
  parameter rdw_mode_t RDW_MODE  = READ_FIRST,
  parameter string     RAM_STYLE = "distributed"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [Awidth-1:0] wr_addr,
  input  logic [Dwidth-1:0] wr_data,
  input  logic              rd_en,
  input  logic [Awidth-1:0] rd_addr,
  output logic [Dwidth-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_start,
  input  logic [Dwidth-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done
);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("pixel_ram_dp: RD_LAT must be 1 or 2");
  end
  if (Dword < 2) begin : g_bad_depth
    $error("pixel_ram_dp: Dword must be at least 2");
  end
  if (RAM_STYLE != "distributed" && RAM_STYLE != "block") begin : g_bad_style
    $error("pixel_ram_dp: RAM_STYLE must be distributed or block");
  end

  logic              clr_we;
  logic [Awidth-1:0] clr_addr;
  logic [Dwidth-1:0] clr_data;

  pixel_ram_clr_fsm #(
    .Dword (Dword),
    .Dwidth(Dwidth),
    .Awidth(Awidth)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_start(clr_start),
    .clr_value(clr_value),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_data (clr_data),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  (* ram_style = RAM_STYLE *)
  logic [Dwidth-1:0] mem [Dword];

  logic              wr_ok, rd_ok, we;
  logic [Awidth-1:0] waddr;
  logic [Dwidth-1:0] wdata, rd_word;

  logic [Dwidth-1:0] d1_q, d1_d, d2_q, d2_d;
  logic              v1_q, v1_d, v2_q, v2_d;

  always_comb begin
    wr_ok = (32'(wr_addr) < Dword);
    rd_ok = (32'(rd_addr) < Dword);
    we    = clr_we | (wr_en & ~clr_busy & wr_ok);
    waddr = clr_we ? clr_addr : wr_addr;
    wdata = clr_we ? clr_data : wr_data;
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem[rd_addr];
      if (RDW_MODE == WRITE_FIRST && we && waddr == rd_addr) begin
        rd_word = wdata;
      end
    end
    d1_d = rd_en ? rd_word : d1_q;
    v1_d = rd_en;
    d2_d = v1_q ? d1_q : d2_q;
    v2_d = v1_q;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_q <= '0;
      v1_q <= 1'b0;
      d2_q <= '0;
      v2_q <= 1'b0;
    end else begin
      d1_q <= d1_d;
      v1_q <= v1_d;
      d2_q <= d2_d;
      v2_q <= v2_d;
    end
  end

  assign rd_data  = (RD_LAT == 2) ? d2_q : d1_q;
  assign rd_valid = (RD_LAT == 2) ? v2_q : v1_q;

endmodule
